um_draft: RTL and testbench
===========================

# um_draft

Top-level user block of the draft tile: an 8-bit registered accumulator ALU driven over the standard tile pins. Each cycle a command (opcode + strobe on the bidirectional pins, operand on the dedicated inputs) updates the accumulator. The accumulator drives the dedicated outputs, and status flags drive the upper bidirectional pins.

## Interface
- No parameters.
- clk     input   1  sole clock; all state updates on rising edge
- rst_n   input   1  reset, synchronous, active-high (1 = reset at the next rising clk edge)
- ena     input   1  tile enable; 0 = hold all state, ignore commands
- ui_in   input   8  operand B
- uio_in  input   8  [2:0] opcode, [3] cmd_valid, [7:4] ignored (pins are outputs)
- uo_out  output  8  accumulator ACC
- uio_out output  8  [3:0] = 0, [4] Z, [5] C, [6] N, [7] P
- uio_oe  output  8  constant 8'hF0 (upper nibble outputs), also during reset

## Operation
- State: ACC[7:0], C (flag register). Z, N and P are derived combinationally from ACC:
  - Z = (ACC == 0)
  - N = ACC[7]
  - P = XOR of ACC bits (odd parity)
- Command executes at a rising edge when rst_n=0, ena=1 and cmd_valid=1. Level-sensitive: one execution per such cycle, back-to-back allowed.
- Opcodes (B = ui_in):
  - 0 NOP: no change.
  - 1 LOAD: ACC=B, C=0.
  - 2 ADD: {C,ACC} = ACC+B (9-bit sum; C is the carry-out).
  - 3 SUB: ACC = (ACC−B) mod 256; C = 1 iff ACC < B (borrow, unsigned).
  - 4 AND: ACC = ACC&B, C=0.
  - 5 OR: ACC = ACC|B, C=0.
  - 6 XOR: ACC = ACC^B, C=0.
  - 7 ROL: ACC rotated left by B[2:0] (0..7); C = new ACC[0] after the rotate. If B[2:0]=0, ACC is unchanged and C = ACC[0].
- ADD does not consume the incoming C; all arithmetic is unsigned, modulo 256.
- ena=0 or cmd_valid=0: ACC and C hold regardless of opcode or operand.
- Reset: ACC=0 and C=0, so outputs are uo_out=0x00 and uio_out=0x10 (Z=1, P=0). Reset wins over any simultaneous command and over ena=0.

## Timing
- Latency 1 cycle: a command sampled at edge k is visible on uo_out/uio_out immediately after edge k.
- Outputs change only after a clock edge; no combinational path from inputs to outputs.
- Reset asserted mid-sequence takes effect at the next edge; the command on that edge is discarded.
- After rst_n deasserts, the first command is accepted on the first edge with rst_n=0.
- uio_oe is constant and independent of the clock.

## Test plan
- Reset: hold rst_n=1 for 2 cycles with cmd_valid=1, op=LOAD, B=0x55 -> uo_out=0x00, uio_out=0x10, uio_oe=0xF0.
- LOAD 0xF0 then ADD 0x20 -> ACC=0x10, C=1, Z=0, N=0, P=1; then ADD 0x0F -> ACC=0x1F, C=0.
- LOAD 0x05 then SUB 0x06 -> ACC=0xFF, C=1, N=1, P=0; then SUB 0xFF -> ACC=0x00, Z=1, C=0.
- LOAD 0x81 then ROL 1 -> ACC=0x03, C=1; then ROL 0 -> ACC=0x03, C=1. AND 0x02 -> 0x02, C=0; OR 0x80 -> 0x82; XOR 0x82 -> 0x00, Z=1.
- Hold: LOAD 0x3C, then ADD 0x01 with ena=0, then ADD 0x01 with cmd_valid=0 -> ACC stays 0x3C; NOP with valid=1 -> 0x3C.
- Back-to-back: ADD 0x01 on 4 consecutive edges from 0xFE -> 0xFF (C=0), 0x00 (C=1, Z=1), 0x01 (C=0), 0x02. Assert rst_n on the 3rd edge -> 0x00 instead, with the 3rd command lost.

Source files
------------

// File: rtl/um_draft.sv
// rtl/um_draft.sv - 8-bit registered accumulator ALU for the draft tile
//
// Purpose: one command per enabled, valid cycle updates the accumulator ACC
// and carry flag C; ACC drives uo_out and the status flags drive the upper
// bidirectional pins.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst_n    synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   ena      tile enable; 0 holds all state
//   ui_in    operand B
//   uio_in   [2:0] opcode, [3] cmd_valid, [7:4] unused (pins are outputs)
//   uo_out   accumulator ACC
//   uio_out  [7] P (odd parity), [6] N, [5] C, [4] Z, [3:0] zero
//   uio_oe   constant 8'hF0

module um_draft (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_ROL  = 3'd7
  } op_e;

  logic [7:0]  acc_q, acc_d;
  logic        c_q, c_d;
  logic [8:0]  sum;
  logic [8:0]  diff;
  logic [15:0] rot;
  logic        cmd_valid;
  op_e         op;

  // Upper nibble of uio_in is driven by this block, so its input value is meaningless.
  logic unused_uio_in;
  assign unused_uio_in = ^uio_in[7:4];

  assign cmd_valid = uio_in[3];
  assign op        = op_e'(uio_in[2:0]);

  // Borrow of ACC-B appears as bit 8 of the 9-bit difference.
  assign sum  = {1'b0, acc_q} + {1'b0, ui_in};
  assign diff = {1'b0, acc_q} - {1'b0, ui_in};
  // Rotate by shifting a doubled copy; the upper byte is the rotated value.
  assign rot  = {acc_q, acc_q} << ui_in[2:0];

  always_comb begin
    acc_d = acc_q;
    c_d   = c_q;
    unique case (op)
      OP_NOP:  ;
      OP_LOAD: begin acc_d = ui_in;          c_d = 1'b0;    end
      OP_ADD:  begin acc_d = sum[7:0];       c_d = sum[8];  end
      OP_SUB:  begin acc_d = diff[7:0];      c_d = diff[8]; end
      OP_AND:  begin acc_d = acc_q & ui_in;  c_d = 1'b0;    end
      OP_OR:   begin acc_d = acc_q | ui_in;  c_d = 1'b0;    end
      OP_XOR:  begin acc_d = acc_q ^ ui_in;  c_d = 1'b0;    end
      OP_ROL:  begin acc_d = rot[15:8];      c_d = rot[8];  end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc_q <= 8'h00;
      c_q   <= 1'b0;
    end else if (ena && cmd_valid) begin
      acc_q <= acc_d;
      c_q   <= c_d;
    end
  end

  // Flags depend only on registered state, so outputs never see inputs combinationally.
  assign uo_out  = acc_q;
  assign uio_out = {^acc_q, acc_q[7], c_q, (acc_q == 8'h00), 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_um_draft.sv
// tb/tb_um_draft.sv - scoreboard testbench for um_draft
module tb_um_draft;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  um_draft dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int n_step = 0;
  int m_acc  = 0;
  int m_c    = 0;
  logic [15:0] exp_q[$];

  task automatic check(string name, int idx, logic [7:0] got, logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s step %0d: got %02h expected %02h", name, idx, got, exp);
  endtask

  function automatic logic [7:0] flags(int a, int c);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += (a >> i) & 1;
    return {ones % 2 == 1, a >= 128, c != 0, a == 0, 4'b0000};
  endfunction

  // Reference model: plain integer arithmetic on the command rules.
  task automatic model(bit rst, bit en, bit v, int op, int b);
    if (rst) begin
      m_acc = 0; m_c = 0;
    end else if (en && v) begin
      case (op)
        1: begin m_acc = b; m_c = 0; end
        2: begin m_c = (m_acc + b > 255); m_acc = (m_acc + b) % 256; end
        3: begin m_c = (m_acc < b); m_acc = (m_acc - b + 256) % 256; end
        4: begin m_acc = m_acc & b; m_c = 0; end
        5: begin m_acc = m_acc | b; m_c = 0; end
        6: begin m_acc = m_acc ^ b; m_c = 0; end
        7: begin
          for (int i = 0; i < b % 8; i++) m_acc = (m_acc * 2) % 256 + m_acc / 128;
          m_c = m_acc % 2;
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(bit rst, bit en, bit v, int op, int b);
    logic [3:0] junk;
    logic [7:0] a8;
    junk = 4'($urandom);
    @(negedge clk);
    rst_n  = rst;
    ena    = en;
    ui_in  = 8'(b);
    uio_in = {junk, v, 3'(op)};
    @(posedge clk);
    model(rst, en, v, op, b);
    a8 = 8'(m_acc);
    exp_q.push_back({a8, flags(m_acc, m_c)});
  endtask

  // Monitor: every cycle after an edge the DUT presents a fresh state.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      n_step++;
      check("uo_out", n_step, uo_out, e[15:8]);
      check("uio_out", n_step, uio_out, e[7:0]);
      check("uio_oe", n_step, uio_oe, 8'hF0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with a competing LOAD
    step(1, 1, 1, 1, 8'h55);
    step(1, 1, 1, 1, 8'h55);
    // add with carry
    step(0, 1, 1, 1, 8'hF0);
    step(0, 1, 1, 2, 8'h20);
    step(0, 1, 1, 2, 8'h0F);
    // subtract with borrow
    step(0, 1, 1, 1, 8'h05);
    step(0, 1, 1, 3, 8'h06);
    step(0, 1, 1, 3, 8'hFF);
    // rotate and logic ops
    step(0, 1, 1, 1, 8'h81);
    step(0, 1, 1, 7, 8'h01);
    step(0, 1, 1, 7, 8'h00);
    step(0, 1, 1, 4, 8'h02);
    step(0, 1, 1, 5, 8'h80);
    step(0, 1, 1, 6, 8'h82);
    // hold conditions
    step(0, 1, 1, 1, 8'h3C);
    step(0, 0, 1, 2, 8'h01);
    step(0, 1, 0, 2, 8'h01);
    step(0, 1, 1, 0, 8'h77);
    // back-to-back, then reset on the 3rd edge
    step(0, 1, 1, 1, 8'hFE);
    repeat (4) step(0, 1, 1, 2, 8'h01);
    step(0, 1, 1, 1, 8'hFE);
    step(0, 1, 1, 2, 8'h01);
    step(0, 1, 1, 2, 8'h01);
    step(1, 1, 1, 2, 8'h01);
    step(0, 1, 1, 2, 8'h01);
    // reset wins over ena=0
    step(0, 1, 1, 1, 8'h99);
    step(1, 0, 0, 1, 8'h99);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit r, e, v;
      r = ($urandom_range(0, 31) == 0);
      e = ($urandom_range(0, 7) != 0);
      v = ($urandom_range(0, 7) != 0);
      step(r, e, v, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
